uart_tx_scheduler: RTL



---
 rtl/uart_tx_scheduler.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one UART transmit line between
// NUM_REQ byte requesters. It latches the winning byte and sends an 8N1-style
// frame (start, DATA_W data bits LSB first, stop) using its own baud divider.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the
// data bits. While the parity bit is sent, state still reports DATA.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_W       = 8,
  localparam int GW          = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      tx,
  output logic                      busy,
  output logic [GW-1:0]             grant_id,
  output logic [1:0]                state
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  state_t              state_r, state_nx;
  logic [BAUD_W-1:0]   baud_r, baud_nx;
  logic [BIT_W-1:0]    bit_r, bit_nx;
  logic [DATA_W-1:0]   shift_r, shift_nx;
  logic [GW-1:0]       ptr_r, ptr_nx;
  logic [GW-1:0]       grant_r, grant_nx;
  logic [NUM_REQ-1:0]  ack_r, ack_nx;
  logic                tx_r, tx_nx;
  logic                busy_r;
  logic                found;
  logic [GW-1:0]       winner;
  logic [GW-1:0]       cand;
  logic [DATA_W-1:0]   win_byte;
  logic                baud_end;
  logic                last_bit;
  logic                data_done;
`ifdef UART_TX_PARITY_EN
  logic                par_r, par_nx;
  logic                par_phase_r, par_phase_nx;
`endif

  assign baud_end = (baud_r == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_bit = (bit_r == BIT_W'(DATA_W - 1));
`ifdef UART_TX_PARITY_EN
  assign data_done = last_bit && par_phase_r;
`else
  assign data_done = last_bit;
`endif

  // Round-robin search: first requester at or above the pointer, wrapping.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand     = '0;
    win_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = GW'((int'(ptr_r) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (winner == GW'(j)) begin
        win_byte = data_in[j*DATA_W +: DATA_W];
      end
    end
  end

  // Frame state register; frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else if (ena) begin
      state_r <= state_nx;
    end else begin
      state_r <= state_r;
    end
  end

  // Next frame state: advance on bit boundaries only.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE:    if (found) state_nx = START; else state_nx = IDLE;
      START:   if (baud_end) state_nx = DATA; else state_nx = START;
      DATA:    if (baud_end && data_done) state_nx = STOP; else state_nx = DATA;
      STOP:    if (baud_end) state_nx = IDLE; else state_nx = STOP;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath next values: grant/latch in IDLE, then bit sequencing.
  always_comb begin
    tx_nx    = tx_r;
    baud_nx  = baud_r;
    bit_nx   = bit_r;
    shift_nx = shift_r;
    ptr_nx   = ptr_r;
    grant_nx = grant_r;
    ack_nx   = '0;
`ifdef UART_TX_PARITY_EN
    par_nx       = par_r;
    par_phase_nx = par_phase_r;
`endif
    case (state_r)
      IDLE: begin
        if (found) begin
          shift_nx = win_byte;
          grant_nx = winner;
          for (int j = 0; j < NUM_REQ; j++) begin
            ack_nx[j] = (winner == GW'(j));
          end
          ptr_nx  = GW'((int'(winner) + 1) % NUM_REQ);
          tx_nx   = 1'b0;
          baud_nx = '0;
`ifdef UART_TX_PARITY_EN
          par_nx       = ^win_byte;
          par_phase_nx = 1'b0;
`endif
        end else begin
          tx_nx = 1'b1;
        end
      end
      START: begin
        if (baud_end) begin
          tx_nx   = shift_r[0];
          baud_nx = '0;
          bit_nx  = '0;
        end else begin
          baud_nx = baud_r + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_nx = '0;
          if (last_bit) begin
`ifdef UART_TX_PARITY_EN
            if (!par_phase_r) begin
              par_phase_nx = 1'b1;
              tx_nx        = par_r;
            end else begin
              par_phase_nx = 1'b0;
              tx_nx        = 1'b1;
            end
`else
            tx_nx = 1'b1;
`endif
          end else begin
            shift_nx = shift_r >> 1;
            bit_nx   = bit_r + BIT_W'(1);
            tx_nx    = shift_r[1];
          end
        end else begin
          baud_nx = baud_r + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_nx = '0;
          tx_nx   = 1'b1;
        end else begin
          baud_nx = baud_r + BAUD_W'(1);
        end
      end
      default: begin
        tx_nx   = 1'b1;
        baud_nx = '0;
      end
    endcase
  end

  // Datapath registers; ack is cleared on every non-accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      baud_r  <= '0;
      bit_r   <= '0;
      shift_r <= '0;
      ptr_r   <= '0;
      grant_r <= '0;
      ack_r   <= '0;
`ifdef UART_TX_PARITY_EN
      par_r       <= 1'b0;
      par_phase_r <= 1'b0;
`endif
    end else if (ena) begin
      tx_r    <= tx_nx;
      busy_r  <= (state_nx != IDLE);
      baud_r  <= baud_nx;
      bit_r   <= bit_nx;
      shift_r <= shift_nx;
      ptr_r   <= ptr_nx;
      grant_r <= grant_nx;
      ack_r   <= ack_nx;
`ifdef UART_TX_PARITY_EN
      par_r       <= par_nx;
      par_phase_r <= par_phase_nx;
`endif
    end else begin
      ack_r <= '0;
    end
  end

  assign tx       = tx_r;
  assign busy     = busy_r;
  assign grant_id = grant_r;
  assign ack      = ack_r;
  assign state    = state_r;

endmodule
